// File: rtl/hs32_arb_pkg.sv
// Shared types and constants for the HS32 two-port memory arbiter.
// Round-robin tie breaking is enabled by defining HS32_ARB_ROUNDROBIN_EN.
package hs32_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic ARB_PORT_FETCH = 1'b0;
    localparam logic ARB_PORT_DATA  = 1'b1;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/hs32_arb_timer.sv
// Clearable up-counter that flags the last wait cycle of a bus transaction.
// Part of hs32_mem_arbiter (HS32_ARB_ROUNDROBIN_EN selects tie policy there).
module hs32_arb_timer
    import hs32_arb_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    // High on the edge where the count would reach TIMEOUT.
    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/hs32_mem_arbiter.sv
// Two-port (fetch/data) word arbiter onto one strobed memory bus with timeout.
// Define HS32_ARB_ROUNDROBIN_EN for alternating tie grants; default is data-first.
module hs32_mem_arbiter
    import hs32_arb_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] dtw0,
    input  logic [31:0] dtw1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic        reqm0,
    input  logic        reqm1,
    output logic [31:0] dtr0,
    output logic [31:0] dtr1,
    output logic        ackm0,
    output logic        ackm1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] maddr,
    output logic [31:0] mdtw,
    output logic        mrw,
    output logic        mstb,
    input  logic [31:0] mdtr,
    input  logic        mack
);

    arb_state_t state;
    logic       gnt;
    logic       pick;
    logic       any_req;
    logic       expired;

    assign any_req = reqm0 | reqm1;

`ifdef HS32_ARB_ROUNDROBIN_EN
    logic last_gnt;

    always_comb begin
        pick = reqm1 ? ARB_PORT_DATA : ARB_PORT_FETCH;
        if (reqm0 && reqm1) begin
            pick = ~last_gnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= ARB_PORT_DATA;
        end else if (state == IDLE && any_req) begin
            last_gnt <= pick;
        end
    end
`else
    always_comb begin
        pick = reqm1 ? ARB_PORT_DATA : ARB_PORT_FETCH;
    end
`endif

    hs32_arb_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != BUSY),
        .en      (state == BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt   <= ARB_PORT_FETCH;
            maddr <= '0;
            mdtw  <= '0;
            mrw   <= 1'b0;
            mstb  <= 1'b0;
            dtr0  <= '0;
            dtr1  <= '0;
            ackm0 <= 1'b0;
            ackm1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
        end else begin
            ackm0 <= 1'b0;
            ackm1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= pick;
                        maddr <= pick ? addr1 : addr0;
                        mdtw  <= pick ? dtw1 : dtw0;
                        mrw   <= pick ? rw1 : rw0;
                        mstb  <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // A late mack on the expiry edge still counts as success.
                    if (mack) begin
                        mstb  <= 1'b0;
                        state <= RESP;
                        if (gnt) begin
                            dtr1  <= mrw ? '0 : mdtr;
                            err1  <= 1'b0;
                            ackm1 <= 1'b1;
                        end else begin
                            dtr0  <= mrw ? '0 : mdtr;
                            err0  <= 1'b0;
                            ackm0 <= 1'b1;
                        end
                    end else if (expired) begin
                        mstb  <= 1'b0;
                        state <= RESP;
                        if (gnt) begin
                            dtr1  <= '0;
                            err1  <= 1'b1;
                            ackm1 <= 1'b1;
                        end else begin
                            dtr0  <= '0;
                            err0  <= 1'b1;
                            ackm0 <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
